// File: rtl/ecg_rpeak_detector.sv
// rtl/ecg_rpeak_detector.sv - threshold-based R-peak detector with adaptive threshold and RR interval
module ecg_rpeak_detector #(
  parameter int DATA_W      = 16,
  parameter int RR_W        = 12,
  parameter int THRESH_INIT = 2000,
  parameter int THRESH_MIN  = 500,
  parameter int REFRACT     = 72,
  parameter int MAX_WIDTH   = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic [DATA_W-1:0] peak_amp,
  output logic [RR_W-1:0]   rr_interval,
  output logic [DATA_W-1:0] threshold,
  output logic [1:0]        det_state
);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, REFR = 2'd2} state_t;

  localparam int WW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(MAX_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REFRACT - 1);
  localparam logic signed [DATA_W-1:0] THR_INIT = DATA_W'(THRESH_INIT);
  localparam logic signed [DATA_W+1:0] THR_LO = (DATA_W + 2)'(THRESH_MIN);
  localparam logic signed [DATA_W+1:0] THR_HI = (DATA_W + 2)'((2 ** (DATA_W - 1)) - 1);

  state_t                    state;
  logic                      run;
  logic                      first;
  logic signed [DATA_W-1:0]  max_r;
  logic signed [DATA_W-1:0]  thr_r;
  logic [RR_W-1:0]           cnt;
  logic [WW-1:0]             width_cnt;
  logic [RW-1:0]             ref_cnt;

  logic                      accept;
  logic                      above;
  logic                      end_peak;
  logic signed [DATA_W-1:0]  x;
  logic signed [DATA_W-1:0]  max_next;
  logic [RR_W-1:0]           cnt_inc;
  logic signed [DATA_W+1:0]  thr_ext;
  logic signed [DATA_W+1:0]  max_ext;
  logic signed [DATA_W+1:0]  thr_calc;
  logic signed [DATA_W+1:0]  thr_clamp;

  assign s_ready   = ~(peak_valid & ~peak_ready);
  assign threshold = thr_r;
  assign det_state = state;

  // run gates acceptance so the first sample lands on the second edge after release
  assign accept   = s_valid & s_ready & run;
  assign x        = s_data;
  assign above    = x > thr_r;
  assign max_next = (x > max_r) ? x : max_r;
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
  assign end_peak = accept && (state == TRACK) && (!above || (width_cnt == W_LAST));

  always_comb begin
    thr_ext   = {{2{thr_r[DATA_W-1]}}, thr_r};
    max_ext   = {{2{max_next[DATA_W-1]}}, max_next};
    thr_calc  = thr_ext - (thr_ext >>> 2) + (max_ext >>> 3);
    thr_clamp = thr_calc;
    if (thr_calc < THR_LO) thr_clamp = THR_LO;
    else if (thr_calc > THR_HI) thr_clamp = THR_HI;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      run         <= 1'b0;
      first       <= 1'b1;
      max_r       <= '0;
      thr_r       <= THR_INIT;
      cnt         <= '0;
      width_cnt   <= '0;
      ref_cnt     <= '0;
      peak_valid  <= 1'b0;
      peak_amp    <= '0;
      rr_interval <= '0;
    end else begin
      run <= 1'b1;
      if (end_peak) begin
        peak_valid  <= 1'b1;
        peak_amp    <= max_next;
        rr_interval <= first ? '0 : cnt_inc;
        thr_r       <= thr_clamp[DATA_W-1:0];
        first       <= 1'b0;
      end else if (peak_ready) begin
        peak_valid <= 1'b0;
      end
      if (accept) begin
        cnt <= end_peak ? '0 : cnt_inc;
        case (state)
          SEARCH: if (above) begin
            state     <= TRACK;
            max_r     <= x;
            width_cnt <= '0;
          end
          TRACK: begin
            max_r <= max_next;
            if (end_peak) begin
              state   <= REFR;
              ref_cnt <= '0;
            end else begin
              width_cnt <= width_cnt + 1'b1;
            end
          end
          REFR: begin
            if (ref_cnt == R_LAST) state <= SEARCH;
            else ref_cnt <= ref_cnt + 1'b1;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ecg_rpeak_detector.sv
// tb/tb_ecg_rpeak_detector.sv - directed scoreboard bench for ecg_rpeak_detector
module tb_ecg_rpeak_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        peak_valid;
  logic        peak_ready;
  logic [15:0] peak_amp;
  logic [11:0] rr_interval;
  logic [15:0] threshold;
  logic [1:0]  det_state;

  typedef struct {int amp; int rr; int thr;} rec_t;
  rec_t sb[$];
  rec_t last_exp;

  int tests = 0;
  int fails = 0;
  int acc = 0;
  int last_term = 0;
  bit first_m = 1'b1;
  int thr_m = 2000;

  ecg_rpeak_detector dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_amp(peak_amp),
    .rr_interval(rr_interval), .threshold(threshold), .det_state(det_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int thr_upd(input int thr, input int amp);
    int t;
    t = thr - (thr >>> 2) + (amp >>> 3);
    if (t < 500) t = 500;
    if (t > 32767) t = 32767;
    return t;
  endfunction

  // called just before driving the sample that should terminate a peak
  task automatic expect_peak(input int amp);
    rec_t r;
    int rr;
    rr = first_m ? 0 : (acc - last_term);
    if (rr > 4095) rr = 4095;
    thr_m = thr_upd(thr_m, amp);
    r.amp = amp; r.rr = rr; r.thr = thr_m;
    sb.push_back(r);
    last_exp = r;
    last_term = acc;
    first_m = 1'b0;
  endtask

  task automatic step(input int x);
    s_data = 16'(x);
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    acc++;
  endtask

  task automatic pulse();
    step(0); step(0); step(3000);
    chk("pulse_track", int'(det_state), 1);
    step(5000); step(4000);
    expect_peak(5000);
    step(1000);
    chk("pulse_refract", int'(det_state), 2);
    chk("pulse_latency", int'(peak_valid), 1);
  endtask

  always @(negedge clk) begin
    if (reset && peak_valid && peak_ready) begin
      if (sb.size() == 0) chk("unexpected_peak", sb.size(), 1);
      else begin
        rec_t r;
        r = sb.pop_front();
        chk("peak_amp", int'($signed(peak_amp)), r.amp);
        chk("rr_interval", int'(rr_interval), r.rr);
        chk("threshold", int'($signed(threshold)), r.thr);
      end
    end
  end

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; peak_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(det_state), 0);
    chk("rst_peak_valid", int'(peak_valid), 0);
    chk("rst_amp", int'(peak_amp), 0);
    chk("rst_rr", int'(rr_interval), 0);
    chk("rst_thr", int'(threshold), 2000);
    chk("rst_s_ready", int'(s_ready), 1);

    // first edge after release must not accept the sample
    reset = 1'b1; s_valid = 1'b1; s_data = 16'd9000;
    @(posedge clk);
    #1;
    chk("release_first_edge", int'(det_state), 0);

    // single pulse, then second pulse 300 samples later
    pulse(); step(0);
    repeat (293) step(0);
    pulse(); step(0);
    chk("thr_after_two", int'($signed(threshold)), thr_m);

    // stalled consumer
    repeat (80) step(0);
    peak_ready = 1'b0;
    pulse();
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 16'd7000;
      chk("stall_s_ready", int'(s_ready), 0);
      chk("stall_amp", int'($signed(peak_amp)), last_exp.amp);
      chk("stall_rr", int'(rr_interval), last_exp.rr);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0; peak_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", int'(peak_valid), 0);

    // above-threshold pulse inside the refractory window
    for (int i = 0; i < 40; i++) begin
      case (i)
        29: step(3000);
        30: step(5000);
        31: step(4000);
        32: step(1000);
        default: step(0);
      endcase
      chk("refract_hold", int'(det_state), 2);
    end
    repeat (40) step(0);
    chk("refract_exit", int'(det_state), 0);

    // plateau forces a peak after the maximum track width
    for (int i = 0; i < 60; i++) begin
      if (i == 40) expect_peak(6000);
      step(6000);
      if (i == 39) chk("width_still_track", int'(det_state), 1);
      if (i == 40) chk("width_forced_end", int'(det_state), 2);
    end
    chk("width_refract", int'(det_state), 2);

    // reset mid-track discards the partial peak
    repeat (80) step(0);
    step(0); step(3000); step(5000);
    chk("pre_reset_track", int'(det_state), 1);
    reset = 1'b0;
    #1;
    chk("async_state", int'(det_state), 0);
    chk("async_peak_valid", int'(peak_valid), 0);
    chk("async_amp", int'(peak_amp), 0);
    chk("async_rr", int'(rr_interval), 0);
    chk("async_thr", int'(threshold), 2000);
    chk("async_s_ready", int'(s_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; s_valid = 1'b0;
    first_m = 1'b1; thr_m = 2000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      step(0);
      chk("post_reset_no_peak", int'(peak_valid), 0);
    end
    pulse(); step(0);

    repeat (3) step(0);
    s_valid = 1'b0;
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
